pdm_dac: RTL

Converts the per-channel linear volume words produced by the channel attenuation stage back into a physical signal: it mixes all channel volumes into one sample and drives a single-bit first-order delta-sigma (PDM) output pin for an external RC filter. It sits at the very end of the PSG audio path, between the attenuators and the chip's audio output pad.

---
 rtl/psg_pkg.sv | 19 +
 rtl/volume_mixer.sv | 22 ++
 rtl/pdm_dac.sv | 59 +++++
 3 files changed

// File: rtl/psg_pkg.sv
// Shared PSG audio-path definitions: volume word type and mixer/DAC sizing helpers.
package psg_pkg;

  localparam int DEF_VOLUME_BITS = 15;
  localparam int DEF_CHANNELS    = 3;

  // Linear volume word as produced by the channel attenuation stage.
  typedef logic [DEF_VOLUME_BITS-1:0] volume_t;

  // Sum width that can hold CHANNELS full-scale words without overflow.
  function automatic int sum_bits(input int volume_bits, input int channels);
    return volume_bits + $clog2(channels);
  endfunction

  function automatic int full_scale(input int volume_bits, input int channels);
    return channels * ((1 << volume_bits) - 1);
  endfunction

endpackage

// File: rtl/volume_mixer.sv
// Combinational unsigned sum of all channel volume words on a flat bus.
module volume_mixer
  import psg_pkg::*;
#(
  parameter int VOLUME_BITS = DEF_VOLUME_BITS,
  parameter int CHANNELS    = DEF_CHANNELS
) (
  input  logic [CHANNELS*VOLUME_BITS-1:0]             vol_in,
  output logic [sum_bits(VOLUME_BITS, CHANNELS)-1:0]  sum
);

  localparam int SUM_BITS = sum_bits(VOLUME_BITS, CHANNELS);

  // NOTE: the default assignment before the loop keeps always_comb free of latches.
  always_comb begin
    sum = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum = sum + SUM_BITS'(vol_in[k*VOLUME_BITS +: VOLUME_BITS]);
    end
  end

endmodule

// File: rtl/pdm_dac.sv
// Mixes channel volumes into one held sample and drives a first-order delta-sigma PDM bit.
module pdm_dac
  import psg_pkg::*;
#(
  parameter int VOLUME_BITS = DEF_VOLUME_BITS,
  parameter int CHANNELS    = DEF_CHANNELS
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       enable,
  input  logic                                       sample_stb,
  input  logic [CHANNELS*VOLUME_BITS-1:0]            vol_in,
  output logic [sum_bits(VOLUME_BITS, CHANNELS)-1:0] sample_out,
  output logic                                       pdm_out
);

  localparam int SUM_BITS = sum_bits(VOLUME_BITS, CHANNELS);
  localparam int ACC_BITS = SUM_BITS + 1;
  localparam logic [ACC_BITS-1:0] FULL_SCALE = ACC_BITS'(full_scale(VOLUME_BITS, CHANNELS));

  logic [SUM_BITS-1:0] mix_sum;
  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS-1:0] acc_next;

  volume_mixer #(
    .VOLUME_BITS (VOLUME_BITS),
    .CHANNELS    (CHANNELS)
  ) u_mixer (
    .vol_in (vol_in),
    .sum    (mix_sum)
  );

  // Uses the currently held sample, so a same-cycle strobe only affects the next step.
  assign acc_next = acc + {1'b0, sample_out};

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out <= '0;
      acc        <= '0;
      pdm_out    <= 1'b0;
    end else begin
      if (sample_stb) begin
        sample_out <= mix_sum;
      end
      if (!enable) begin
        acc     <= '0;
        pdm_out <= 1'b0;
      end else if (acc_next >= FULL_SCALE) begin
        acc     <= acc_next - FULL_SCALE;
        pdm_out <= 1'b1;
      end else begin
        acc     <= acc_next;
        pdm_out <= 1'b0;
      end
    end
  end

endmodule
